// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_idx_t;

    // Byte addresses must be word aligned: these low bits must be zero.
    localparam logic [1:0]  ALIGN_MASK = 2'b11;
    localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant logic with the last-granted pointer.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o,
    output port_idx_t  gnt_idx_o
);

    port_idx_t last_q, last_d;

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        gnt_o     = 2'b00;
        gnt_idx_o = PORT0;
        last_d    = last_q;
        if (en_i) begin
            // Port 0 wins a tie only when port 1 was served last.
            if (req_i[0] && (!req_i[1] || last_q == PORT1)) begin
                gnt_o     = 2'b01;
                gnt_idx_o = PORT0;
                last_d    = PORT0;
            end else if (req_i[1]) begin
                gnt_o     = 2'b10;
                gnt_idx_o = PORT1;
                last_d    = PORT1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= PORT1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates two request ports onto a single-ported data memory with a
// fixed grant / access / response sequence per transaction.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [DATA_W-1:0] addr0,
    input  logic [DATA_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [DATA_W-1:0] ADDR_LIMIT = DATA_W'(WORD_BYTES * MEM_WORDS);

    state_e            state_q, state_d;
    port_idx_t         owner_q, owner_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [1:0]        arb_gnt;
    port_idx_t         arb_idx;
    logic              sel_we;
    logic [DATA_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_arb2 u_rr_arb2 (
        .clk       (clk),
        .rst       (rst),
        .en_i      (state_q == IDLE && !rst),
        .req_i     ({req1, req0}),
        .gnt_o     (arb_gnt),
        .gnt_idx_o (arb_idx)
    );

    always_comb begin
        sel_we    = (arb_idx == PORT1) ? we1    : we0;
        sel_addr  = (arb_idx == PORT1) ? addr1  : addr0;
        sel_wdata = (arb_idx == PORT1) ? wdata1 : wdata0;
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        err_d     = err_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        gnt0      = arb_gnt[0];
        gnt1      = arb_gnt[1];
        rvalid0   = 1'b0;
        rvalid1   = 1'b0;
        rdata0    = '0;
        rdata1    = '0;
        err0      = 1'b0;
        err1      = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        case (state_q)
            IDLE: begin
                if (|arb_gnt) begin
                    state_d = ACCESS;
                    owner_d = arb_idx;
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    err_d   = ((sel_addr[1:0] & ALIGN_MASK) != 2'b00) || (sel_addr >= ADDR_LIMIT);
                    rdata_d = '0;
                end
            end
            ACCESS: begin
                state_d   = RESP;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                // A faulting address never touches the memory; rdata stays 0.
                if (!err_q) begin
                    mem_read  = !we_q;
                    mem_write = we_q;
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
                if (owner_q == PORT1) begin
                    rvalid1 = 1'b1;
                    rdata1  = rdata_q;
                    err1    = err_q;
                end else begin
                    rvalid0 = 1'b1;
                    rdata0  = rdata_q;
                    err0    = err_q;
                end
            end
            default: state_d = IDLE;
        endcase

        // Reset silences every output at once, including a write already in ACCESS.
        if (rst) begin
            gnt0      = 1'b0;
            gnt1      = 1'b0;
            rvalid0   = 1'b0;
            rvalid1   = 1'b0;
            rdata0    = '0;
            rdata1    = '0;
            err0      = 1'b0;
            err1      = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= PORT0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: expected responses go into a scoreboard
// queue at grant time and a monitor compares them when rvalid appears.
module tb_dmem_arbiter;

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [0:255];
    logic        init_mem;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        sb [$];
    exp_t        mon_e;
    int          mon_p;

    dmem_arbiter #(.DATA_W(32), .MEM_WORDS(256)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .err0      (err0),
        .err1      (err1),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Data memory: combinational read, clocked write; word i preloads to i+7.
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'(i) + 32'd7;
        end else if (mem_write) begin
            mem[mem_addr[9:2]] <= mem_wdata;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ctrl"}, 64'({gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_read, mem_write}), 64'd0);
        check({tag, "_rdata"}, {rdata0, rdata1}, 64'd0);
        check({tag, "_mem_bus"}, {mem_addr, mem_wdata}, 64'd0);
    endtask

    task automatic set_port(input int port, input logic r, input logic we,
                            input logic [31:0] addr, input logic [31:0] wdata);
        if (port == 1) begin
            req1 = r; we1 = we; addr1 = addr; wdata1 = wdata;
        end else begin
            req0 = r; we0 = we; addr0 = addr; wdata0 = wdata;
        end
    endtask

    // One isolated transaction: grant in the request cycle, memory at +1, rvalid at +2.
    task automatic do_txn(input string tag, input int port, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err);
        int   waited;
        logic g;
        waited = 0;
        g      = 1'b0;
        @(posedge clk); #1;
        set_port(port, 1'b1, we, addr, wdata);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            g = (port == 1) ? gnt1 : gnt0;
            if (g) break;
            waited++;
        end
        check({tag, "_gnt_latency"}, 64'(waited), 64'd0);
        if (g) sb.push_back('{port, exp_rdata, exp_err});
        @(posedge clk); #1;
        // Scramble the port's fields: the transaction must use the registered copy.
        set_port(port, 1'b0, ~we, 32'hFFFF_FFF0, ~wdata);
        @(negedge clk);
        check({tag, "_mem_read"},  64'(mem_read),  64'(!we && !exp_err));
        check({tag, "_mem_write"}, 64'(mem_write), 64'(we && !exp_err));
        if (!exp_err) check({tag, "_mem_addr"}, 64'(mem_addr), 64'(addr));
        if (!exp_err && we) check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(wdata));
        @(negedge clk);
        check({tag, "_rvalid_at_n2"}, 64'((port == 1) ? rvalid1 : rvalid0), 64'd1);
        @(posedge clk); #1;
    endtask

    // Monitor: every completion must match the oldest expected response.
    always @(negedge clk) begin
        if (rvalid0 || rvalid1) begin
            mon_p = rvalid1 ? 1 : 0;
            check("rsp_single_port", 64'(rvalid0 & rvalid1), 64'd0);
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rsp_unexpected: port %0d rvalid with nothing pending", mon_p);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_port", 64'(mon_p), 64'(mon_e.port));
                check("rsp_rdata", 64'((mon_p == 1) ? rdata1 : rdata0), 64'(mon_e.rdata));
                check("rsp_err", 64'((mon_p == 1) ? err1 : err0), 64'(mon_e.err));
                check("rsp_other_quiet",
                      (mon_p == 1) ? {31'd0, err0, rdata0} : {31'd0, err1, rdata1}, 64'd0);
            end
        end
    end

    initial begin
        int p;
        int prev;
        int got;
        rst = 1'b1;
        init_mem = 1'b1;
        set_port(0, 1'b1, 1'b0, 32'h0C, 32'h0);
        set_port(1, 1'b0, 1'b0, 32'h0,  32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        init_mem = 1'b0;
        req0 = 1'b0;

        // Single reads/writes and read-back.
        do_txn("p0_read_0c", 0, 1'b0, 32'h0C, 32'h0, 32'd10, 1'b0);
        do_txn("p1_write_20", 1, 1'b1, 32'h20, 32'hDEAD_BEEF, 32'h0, 1'b0);
        do_txn("p0_read_20", 0, 1'b0, 32'h20, 32'h0, 32'hDEAD_BEEF, 1'b0);

        // Misaligned and out-of-range addresses.
        do_txn("p0_misaligned", 0, 1'b0, 32'h0E, 32'h0, 32'h0, 1'b1);
        do_txn("p1_out_of_range", 1, 1'b1, 32'h400, 32'h1234_5678, 32'h0, 1'b1);
        check("range_write_dropped", 64'(mem[0]), 64'd7);

        // Reset lands on the ACCESS cycle of a port 1 write.
        @(posedge clk); #1;
        set_port(1, 1'b1, 1'b1, 32'h10, 32'hBAD0_0004);
        @(negedge clk);
        check("abort_gnt1", 64'(gnt1), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check_quiet("abort_in_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_quiet("abort_after");
        @(negedge clk);
        check("abort_word4", 64'(mem[4]), 64'd11);
        do_txn("p0_read_10", 0, 1'b0, 32'h10, 32'h0, 32'd11, 1'b0);

        // Re-establish pointer with a fresh reset, then hold both requests.
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        set_port(0, 1'b1, 1'b0, 32'h0C, 32'h0);
        set_port(1, 1'b1, 1'b0, 32'h10, 32'h0);
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            got = 0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (gnt0 || gnt1) begin
                    got = 1;
                    break;
                end
            end
            check("rr_grant_seen", 64'(got), 64'd1);
            if (got == 0) break;
            p = gnt1 ? 1 : 0;
            check("rr_order", 64'(p), 64'(k % 2));
            check("rr_gnt_onehot", 64'(gnt0 & gnt1), 64'd0);
            if (k > 0) check("rr_spacing", 64'(cyc - prev), 64'd3);
            prev = cyc;
            sb.push_back('{p, (p == 1) ? 32'd11 : 32'd10, 1'b0});
        end
        @(posedge clk); #1;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (2) @(negedge clk);

        // A request raised during ACCESS waits for the next IDLE cycle.
        @(posedge clk); #1;
        set_port(0, 1'b1, 1'b0, 32'h0C, 32'h0);
        @(negedge clk);
        check("late_gnt0", 64'(gnt0), 64'd1);
        sb.push_back('{0, 32'd10, 1'b0});
        @(posedge clk); #1;
        set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_port(1, 1'b1, 1'b1, 32'h30, 32'h5);
        @(negedge clk);
        check("late_no_gnt_access", 64'(gnt1), 64'd0);
        @(negedge clk);
        check("late_no_gnt_resp", 64'(gnt1), 64'd0);
        @(negedge clk);
        check("late_gnt1_idle", 64'(gnt1), 64'd1);
        if (gnt1) sb.push_back('{1, 32'h0, 1'b0});
        @(posedge clk); #1;
        set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        do_txn("p0_read_30", 0, 1'b0, 32'h30, 32'h0, 32'h5, 1'b0);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named as the codebase does (clk, rst).
REQ-002 Parameter DATA_W, default 32, SHALL set the data and address width.
REQ-003 Parameter MEM_WORDS, default 256, SHALL set the number of data-memory words; legal byte addresses are 0 to 4*MEM_WORDS-1.
REQ-004 The ports SHALL be:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req0 / req1  in  1  port request; held until gnt
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  DATA_W  byte address
- wdata0 / wdata1  in  DATA_W  write data
- gnt0 / gnt1  out  1  request accepted, one-cycle pulse
- rvalid0 / rvalid1  out  1  completion pulse
- rdata0 / rdata1  out  DATA_W  read data, valid with rvalid
- err0 / err1  out  1  completion carries an error, valid with rvalid
- mem_read  out  1  data-memory read enable
- mem_write  out  1  data-memory write enable
- mem_addr  out  DATA_W  data-memory byte address
- mem_wdata  out  DATA_W  data-memory write data
- mem_rdata  in  DATA_W  data-memory combinational read data

Function
REQ-005 The FSM SHALL have the states IDLE, ACCESS and RESP; transitions are IDLE->ACCESS on any grant, ACCESS->RESP always, and RESP->IDLE always.
REQ-006 In IDLE, gntX SHALL assert combinationally in the same cycle for exactly one requesting port; no grant is issued in ACCESS or RESP.
REQ-007 Arbitration SHALL be round-robin: on simultaneous req0 and req1, the port not granted last wins; a lone request wins immediately.
REQ-008 On grant, the owner, we, addr and wdata SHALL be registered; the requester may change its fields after the gnt cycle.
REQ-009 In ACCESS, mem_addr and mem_wdata SHALL come from the registers, with mem_read = !we and mem_write = we, each high for exactly one cycle; mem_rdata is captured at the end of ACCESS.
REQ-010 In RESP, the owner's rvalidX SHALL pulse for one cycle, with rdataX equal to the captured word for reads and 0 for writes.
REQ-011 Latency SHALL be fixed: gnt at cycle N, memory access at N+1, rvalid at N+2; peak throughput is one access per 3 cycles.
REQ-012 An address with addr[1:0] != 0, or addr >= 4*MEM_WORDS, SHALL be an error: no mem_read or mem_write pulse in ACCESS, and errX=1 with rdataX=0 in RESP.
REQ-013 When not in ACCESS, mem_read and mem_write SHALL be 0 and mem_addr and mem_wdata SHALL hold 0.
REQ-014 The non-owner's rvalid, rdata and err SHALL stay 0 at all times.
REQ-015 A requester that deasserts req before gnt SHALL be treated as never having requested; no state is kept for it.
REQ-016 A request arriving during ACCESS or RESP SHALL wait; it is arbitrated in the next IDLE cycle together with any other pending request.

Reset
REQ-017 While rst is high, the state SHALL go to IDLE and all outputs SHALL be 0 (gnt, rvalid, rdata, err, mem_read, mem_write, mem_addr, mem_wdata).
REQ-018 Reset SHALL set the last-granted pointer to port 1, so port 0 wins the first tie.
REQ-019 Reset asserted during ACCESS or RESP SHALL abort the transaction: no rvalid afterwards, and a write whose ACCESS cycle coincides with rst is suppressed.

Structure
REQ-020 A shared package dmem_arb_pkg SHALL hold the state enum (IDLE, ACCESS, RESP), the port-index type and the alignment/range-check constant.
REQ-021 One sub-module, rr_arb2, SHALL hold the 2-way round-robin grant logic and the last-granted pointer; everything else is in dmem_arbiter.
REQ-022 The block SHALL connect directly to the existing data memory: mem_read->memRead, mem_write->memWrite, mem_addr->addr, mem_wdata->wdata, mem_rdata<-rdata.

Verification
REQ-023 Port 0 read, addr=0x0C, memory word 3 preloaded to 10 -> gnt0 at N, mem_read at N+1, rvalid0 with rdata0=10 and err0=0 at N+2.
REQ-024 Port 1 write, addr=0x20, wdata=0xDEADBEEF, then port 0 read of 0x20 -> one mem_write pulse, then rdata0=0xDEADBEEF.
REQ-025 req0 and req1 held high together for 4 transactions after reset -> grant order 0,1,0,1, with each gnt 3 cycles apart.
REQ-026 Port 0 read at addr=0x0E, then port 1 write at addr=0x400 -> no mem_read/mem_write pulse; err0=1 then err1=1, each rdata=0.
REQ-027 rst asserted in the ACCESS cycle of a port 1 write to 0x10 -> no rvalid1, word 4 unchanged, all outputs 0 the next cycle.
REQ-028 req1 raised during port 0's ACCESS cycle -> gnt1 in the first IDLE cycle after port 0's RESP; rvalid0 is never asserted for port 1's transaction.
